// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the scoreboarded register file.
//   calc_aw()  : address width for a given register count
//   cnt_max()  : largest value a CNT_W-bit pending-write counter can hold
//   cnt_op_e   : per-register counter action for one clock edge
// ---------------------------------------------------------------------------
package regfile_pkg;

    // Address width needed to index n registers (n is a power of two, >= 2).
    function automatic int calc_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Saturation value of a w-bit counter.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    // Counter action chosen by the per-register scoreboard each cycle.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2,
        CNT_ERR  = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/regfile_sb_sb_counter.sv
// ---------------------------------------------------------------------------
// sb_counter
// Pending-write counter for one architectural register.
//   clk, rst  : clock, synchronous active-high reset
//   alloc_i   : accepted issue targeting this register (increment)
//   wb_i      : writeback targeting this register (decrement)
//   cnt_o     : registered pending-write count
//   err_o     : this edge sees a writeback while the count is zero
// ---------------------------------------------------------------------------
module sb_counter
    import regfile_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_i,
    input  logic             wb_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    cnt_op_e          op_s;

    // Decode alloc/writeback pair into a counter action.
    always_comb begin
        op_s = CNT_HOLD;
        case ({alloc_i, wb_i})
            2'b10: op_s = (cnt_q == MAX) ? CNT_HOLD : CNT_INC;
            2'b01: op_s = (cnt_q == '0)  ? CNT_ERR  : CNT_DEC;
            // Issue and writeback cancel out; an empty counter still flags.
            2'b11: op_s = (cnt_q == '0)  ? CNT_ERR  : CNT_HOLD;
            default: op_s = CNT_HOLD;
        endcase
    end

    // Next count from the chosen action.
    always_comb begin
        cnt_d = cnt_q;
        case (op_s)
            CNT_INC: cnt_d = cnt_q + ONE;
            CNT_DEC: cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = (op_s == CNT_ERR);

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Integer register file with per-register pending-write scoreboard.
//   clk, rst    : clock, synchronous active-high reset
//   rd_addr     : NUM_RD packed read addresses, port k at [k*AW +: AW]
//   rd_data     : NUM_RD packed combinational read data
//   rd_busy     : per port, register has an outstanding write
//   alloc_en    : issue request marking alloc_addr as pending
//   alloc_addr  : destination register being issued
//   alloc_rdy   : alloc accepted this cycle (counter not saturated, or x0)
//   wr_en       : writeback strobe
//   wr_addr     : writeback register
//   wr_data     : writeback data
//   wb_err      : sticky, writeback seen to a register with no pending write
// Build option: define REGFILE_SB_BYPASS_EN for write-first forwarding of
// wr_data and an early busy release on the final writeback.
// Register 0 reads as zero, is never busy and ignores writes.
// ---------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REGS   = 32,
    parameter int  NUM_RD     = 2,
    parameter int  CNT_W      = 2,
    localparam int AW         = calc_aw(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic                     alloc_rdy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [DATA_WIDTH-1:0]            mem_q [NUM_REGS];
    logic [NUM_REGS-1:0][CNT_W-1:0]   cnt_s;
    logic [NUM_REGS-1:0]              err_vec_s;
    logic                             alloc_ok_s;
    logic                             wb_err_q;

    // x0 owns no counter; it is permanently idle and cannot raise an error.
    assign cnt_s[0]     = '0;
    assign err_vec_s[0] = 1'b0;

    assign alloc_rdy  = (alloc_addr == '0) || (cnt_s[alloc_addr] != CNT_MAX);
    assign alloc_ok_s = alloc_en && alloc_rdy;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .alloc_i (alloc_ok_s && (alloc_addr == AW'(r))),
            .wb_i    (wr_en && (wr_addr == AW'(r))),
            .cnt_o   (cnt_s[r]),
            .err_o   (err_vec_s[r])
        );
    end

    // Register array; data lands on every writeback regardless of counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Sticky writeback-underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_err_q <= 1'b0;
        end else if (|err_vec_s) begin
            wb_err_q <= 1'b1;
        end
    end

    assign wb_err = wb_err_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]         ra_s;
        logic [DATA_WIDTH-1:0] data_s;
        logic                  busy_s;

        assign ra_s = rd_addr[k*AW +: AW];

        // Read mux for port k, with optional same-cycle writeback forwarding.
        always_comb begin
            data_s = '0;
            busy_s = 1'b0;
            if (ra_s != '0) begin
                data_s = mem_q[ra_s];
                busy_s = (cnt_s[ra_s] != '0);
`ifdef REGFILE_SB_BYPASS_EN
                if (wr_en && (wr_addr == ra_s)) begin
                    data_s = wr_data;
                    // The retiring write is discounted unless a new issue
                    // to the same register replaces it this cycle.
                    if ((cnt_s[ra_s] != '0) && !(alloc_ok_s && (alloc_addr == ra_s))) begin
                        busy_s = (cnt_s[ra_s] != CNT_W'(1));
                    end else begin
                        busy_s = (cnt_s[ra_s] != '0);
                    end
                end else begin
                    data_s = mem_q[ra_s];
                end
`endif
            end else begin
                data_s = '0;
                busy_s = 1'b0;
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data_s;
        assign rd_busy[k]                          = busy_s;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: the driver applies stimulus, computes the
// expected outputs from an array-based reference model and queues them; a
// monitor on the falling edge pops and compares.
module tb_regfile_sb;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int CW  = 2;
    localparam int AW  = 5;
    localparam int MAXC = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic              alloc_rdy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wb_err;

    regfile_sb #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .NUM_RD     (NRD),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .alloc_rdy  (alloc_rdy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NRD*DW-1:0] data;
        logic [NRD-1:0]    busy;
        logic              rdy;
        logic              err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [DW-1:0] m_mem [NR];
    int            m_cnt [NR];
    bit            m_err;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: outputs are stable by the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], e.data[k*DW +: DW]);
                check($sformatf("rd_busy%0d", k), {31'd0, rd_busy[k]}, {31'd0, e.busy[k]});
            end
            check("alloc_rdy", {31'd0, alloc_rdy}, {31'd0, e.rdy});
            check("wb_err", {31'd0, wb_err}, {31'd0, e.err});
        end
    end

    task automatic drive(input bit chk, input bit r, input bit ae, input int aa,
                         input bit we, input int wa, input logic [DW-1:0] wd,
                         input int ra0, input int ra1);
        exp_t e;
        int   ra [NRD];
        bit   acc;
        @(posedge clk);
        #1;
        rst        = r;
        alloc_en   = ae;
        alloc_addr = AW'(aa);
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = wd;
        rd_addr    = {AW'(ra1), AW'(ra0)};
        ra[0] = ra0;
        ra[1] = ra1;

        e.rdy = (aa == 0) || (m_cnt[aa] < MAXC);
        e.err = m_err;
        acc   = ae && e.rdy;
        for (int k = 0; k < NRD; k++) begin
            if (ra[k] == 0) begin
                e.data[k*DW +: DW] = '0;
                e.busy[k] = 1'b0;
            end else begin
                e.data[k*DW +: DW] = m_mem[ra[k]];
                e.busy[k] = m_cnt[ra[k]] > 0;
`ifdef REGFILE_SB_BYPASS_EN
                if (we && wa == ra[k]) begin
                    e.data[k*DW +: DW] = wd;
                    if (m_cnt[ra[k]] > 0 && !(acc && aa == ra[k]))
                        e.busy[k] = (m_cnt[ra[k]] - 1) > 0;
                end
`endif
            end
        end
        if (chk) exp_q.push_back(e);

        // Model the effect of the coming edge.
        if (r) begin
            for (int i = 0; i < NR; i++) begin
                m_mem[i] = '0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            if (acc && aa != 0 && !(we && wa == aa)) m_cnt[aa] = m_cnt[aa] + 1;
            if (we && wa != 0) begin
                m_mem[wa] = wd;
                if (m_cnt[wa] == 0) m_err = 1'b1;
                else if (!(acc && aa == wa)) m_cnt[wa] = m_cnt[wa] - 1;
            end
        end
    endtask

    task automatic idle(input int ra0, input int ra1);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, '0, ra0, ra1);
    endtask

    initial begin
        rst = 1'b1; alloc_en = 1'b0; alloc_addr = '0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_cnt[i] = 0; end
        m_err = 1'b0;

        // Reset: first edge unchecked (DUT state unknown), then read all.
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, '0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 5, 1'b1, 5, 32'h1111_1111, 5, 0);
        for (int i = 0; i < NR; i++) idle(i, NR - 1 - i);

        // RAW on x5
        drive(1'b1, 1'b0, 1'b1, 5, 1'b0, 0, '0, 5, 0);
        idle(5, 5);
        idle(5, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 5, 32'hDEAD_BEEF, 5, 5);
        idle(5, 5);

        // Saturation on x7
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 7, 1'b0, 0, '0, 7, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 7, 32'h0000_0777, 7, 7);
        drive(1'b1, 1'b0, 1'b1, 7, 1'b0, 0, '0, 7, 0);

        // Simultaneous alloc + wr on x9 with cnt=1
        drive(1'b1, 1'b0, 1'b1, 9, 1'b0, 0, '0, 9, 0);
        drive(1'b1, 1'b0, 1'b1, 9, 1'b1, 9, 32'h0000_1234, 9, 9);
        idle(9, 9);

        // x0 accesses leave wb_err clear
        drive(1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 32'hFFFF_FFFF, 0, 0);
        idle(0, 0);

        // Writeback with nothing pending on x10 -> sticky wb_err
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 10, 32'h0000_00A0, 10, 0);
        idle(10, 0);
        idle(10, 10);

        // Both ports see x3
        drive(1'b1, 1'b0, 1'b1, 3, 1'b0, 0, '0, 3, 3);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 3, 32'h0000_0055, 3, 3);
        idle(3, 3);

        // Reset mid-operation: x4 = 0xAA with two pending
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 4, 1'b0, 0, '0, 4, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 4, 32'h0000_00AA, 4, 4);
        idle(4, 4);
        drive(1'b1, 1'b1, 1'b1, 4, 1'b1, 4, 32'h0000_0BAD, 4, 4);
        idle(4, 4);

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 800; n++) begin
            drive(1'b1, ($urandom_range(0, 63) == 0),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 4, int'($urandom_range(0, 7)),
                  $urandom(),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1))
                                              : int'($urandom_range(0, 7)));
        end

        idle(0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
